// File: rtl/vga_text_fetch.sv
// vga_text_fetch: fetches one text word from a synchronous character memory
// at each frame start (falling vsync) and presents it to the display stage.
// The window index advances on a manual step or on automatic scrolling.
// Optional feature: define VGA_TEXT_HOLD_EN to add a 'hold' input that
// freezes fetching, advancing, frame counting and step capture.
module vga_text_fetch #(
    parameter int ADDR_W          = 8,
    parameter int DATA_W          = 10,
    parameter int FRAMES_PER_STEP = 60,
    parameter int RD_LATENCY      = 1
) (
    input  logic              clk50MHz,
    input  logic              reset,
    input  logic              vsync,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic              auto_scroll,
    input  logic              step,
`ifdef VGA_TEXT_HOLD_EN
    input  logic              hold,
`endif
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] text,
    output logic [ADDR_W-1:0] cur_index,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    localparam logic [15:0] FPS_LAST = 16'(FRAMES_PER_STEP - 1);
    localparam logic [1:0]  LAT_LAST = 2'(RD_LATENCY);

    state_t      state, state_n;
    logic        vs_p0, vs_p1, vs_hist_p2;
    logic        fs_raw, fs, step_in;
    logic        pending;
    logic [15:0] frame_cnt;
    logic        auto_adv;
    logic        accept, capture;
    logic [1:0]  lat_cnt;
    logic [ADDR_W-1:0] idx_new;

    // Index update rule: out-of-window index snaps to 0, otherwise optional +1 with wrap.
    function automatic logic [ADDR_W-1:0] next_index(input logic [ADDR_W-1:0] cur,
                                                     input logic [ADDR_W-1:0] wc,
                                                     input logic adv);
        logic [ADDR_W-1:0] eff;
        logic [ADDR_W:0]   inc;
        eff = (wc == '0) ? ADDR_W'(1) : wc;
        inc = {1'b0, cur} + 1'b1;
        if (cur >= eff)
            next_index = '0;
        else if (!adv)
            next_index = cur;
        else if (inc >= {1'b0, eff})
            next_index = '0;
        else
            next_index = inc[ADDR_W-1:0];
    endfunction

    // vsync synchronizer plus history flop; idle-high after reset so no false edge.
    always_ff @(posedge clk50MHz) begin
        if (reset) begin
            vs_p0      <= 1'b1;
            vs_p1      <= 1'b1;
            vs_hist_p2 <= 1'b1;
        end else begin
            vs_p0      <= vsync;
            vs_p1      <= vs_p0;
            vs_hist_p2 <= vs_p1;
        end
    end

    assign fs_raw = vs_hist_p2 & ~vs_p1;

`ifdef VGA_TEXT_HOLD_EN
    assign fs      = fs_raw & ~hold;
    assign step_in = step & ~hold;
`else
    assign fs      = fs_raw;
    assign step_in = step;
`endif

    assign auto_adv = auto_scroll && (frame_cnt == FPS_LAST);
    assign idx_new  = next_index(cur_index, word_count, pending | auto_adv);

    // FSM state register.
    always_ff @(posedge clk50MHz) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // FSM next state and strobes; frame starts outside IDLE are dropped.
    always_comb begin
        state_n   = state;
        mem_rd_en = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (fs) begin
                    accept  = 1'b1;
                    state_n = S_REQ;
                end
            end
            S_REQ: begin
                mem_rd_en = 1'b1;
                busy      = 1'b1;
                state_n   = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (lat_cnt == LAT_LAST) begin
                    capture = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Step capture: several steps within a frame collapse into one advance.
    always_ff @(posedge clk50MHz) begin
        if (reset)
            pending <= 1'b0;
        else if (accept)
            pending <= step_in;
        else if (step_in)
            pending <= 1'b1;
    end

    // Frame counter for auto scroll; cleared whenever auto scroll is off.
    always_ff @(posedge clk50MHz) begin
        if (reset || !auto_scroll)
            frame_cnt <= '0;
        else if (accept)
            frame_cnt <= auto_adv ? 16'd0 : frame_cnt + 16'd1;
    end

    // Index, read address, latency counter and captured text word.
    always_ff @(posedge clk50MHz) begin
        if (reset) begin
            cur_index <= '0;
            mem_addr  <= '0;
            lat_cnt   <= '0;
            text      <= '0;
        end else begin
            if (accept) begin
                cur_index <= idx_new;
                mem_addr  <= base_addr + idx_new;
            end
            if (state == S_REQ)
                lat_cnt <= 2'd1;
            else if (state == S_WAIT)
                lat_cnt <= lat_cnt + 2'd1;
            if (capture)
                text <= mem_rd_data;
        end
    end

endmodule
